serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial subtractor computing `diff = a - b - bin` over WIDTH clock cycles, LSB first, with a single full-subtractor cell and a registered borrow. It is the subtraction counterpart of the team's full-adder cell. It sits in the arithmetic datapath wherever area matters more than throughput. Operands are captured on a start handshake, and the result is presented with a one-cycle valid pulse.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range 2..64.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request; sampled only while `ready`=1.
- `a` input WIDTH: minuend; captured when the start is accepted.
- `b` input WIDTH: subtrahend; captured when the start is accepted.
- `bin` input 1: borrow in; captured when the start is accepted.
- `ready` output 1: high in IDLE; a new start is accepted this cycle.
- `diff` output WIDTH: result; holds its value until the next completion.
- `bout` output 1: final borrow out (1 = unsigned underflow); holds like `diff`.
- `valid` output 1: one-cycle pulse when `diff`/`bout` update.
- `ovf` output 1: signed two's-complement overflow. Present only with `SERIAL_SUB_OVF_EN`.

## Operation
- States: IDLE, SHIFT.
- IDLE → SHIFT when `start`=1 at an edge:
  - Load `a` and `b` into shift registers.
  - Load the borrow flop with `bin`.
  - Clear the bit counter to 0.
  - `ready` drops.
- SHIFT, each edge, with `ai`=a_sr[0], `bi`=b_sr[0], `bw`=borrow flop:
  - `d` = ai^bi^bw.
  - `bw_next` = (~ai&bi) | (~ai&bw) | (bi&bw).
  - Shift a_sr and b_sr right by one.
  - Shift `d` into the MSB of the working result register.
  - Increment the counter.
- SHIFT → IDLE on the edge that processes bit WIDTH-1. On that same edge:
  - Copy the working register (including that bit) to `diff`.
  - `bout` ← `bw_next`.
  - `valid` ← 1.
  - `ready` ← 1.
- `valid` clears on the following edge.
- `start` while in SHIFT is ignored. `a`, `b` and `bin` are don't-care outside the accepting edge.
- Async reset clears everything, including mid-operation. The in-flight operation is discarded and no `valid` is produced.
- Reset values: `ready`=1, `valid`=0, `diff`=0, `bout`=0, `ovf`=0. State IDLE, counter 0, all shift registers 0.
- Arithmetic:
  - Modulo 2^WIDTH.
  - `bout`=1 exactly when a < b+bin as unsigned numbers.
  - Counter width is $clog2(WIDTH).

## Timing
- Start accepted at edge E0.
- Bit i is processed at edge E(i+1).
- `diff`/`bout`/`valid` are visible after edge E(WIDTH). Latency is WIDTH cycles.
- `ready` is high in the same cycle as `valid`. A start sampled at E(WIDTH+1) is accepted.
- Maximum throughput: one operation per WIDTH+1 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `SERIAL_SUB_OVF_EN` defined:
  - `ovf` port exists.
  - `ovf` updates with `valid`: (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]), using the captured operands.
  - `ovf` holds like `diff`.
- Without the macro: no `ovf` port, and no MSB capture logic.

## Structure
- Package `serial_sub_pkg`:
  - State enum (IDLE, SHIFT).
  - Default-width constant.
  - Helper function computing counter width.
- Sub-module `fullsub_d`:
  - Combinational one-bit full subtractor.
  - Ports: a, b, bi, d, bo.
  - Instantiated once.

## Test plan
WIDTH=8 throughout.
- 0x5A - 0x23, bin=0 → `diff`=0x37, `bout`=0, `ovf`=0. `valid` high exactly one cycle, 8 edges after the accepting edge.
- 0x00 - 0x01, bin=0 → `diff`=0xFF, `bout`=1, `ovf`=0.
- 0x80 - 0x01, bin=0 → `diff`=0x7F, `bout`=0, `ovf`=1 (macro build).
- 0x10 - 0x10, bin=1 → `diff`=0xFF, `bout`=1. Start a second op (0x05 - 0x03) in the `valid` cycle → accepted; `diff`=0x02 after 8 more edges.
- Pulse `start` with 0xFF/0x00 during SHIFT of 0x5A - 0x23 → ignored; result still 0x37, `ready` stays low.
- Assert `rst_n`=0 after 4 SHIFT edges → `ready`=1, `valid`=0, `diff`=0x00, `bout`=0 immediately. No `valid` after release.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// serial_sub_pkg: shared state enum, default width and counter-width helper for the serial subtractor
package serial_sub_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam int DEF_WIDTH = 8;
  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/operand/result bundle; ovf exists only with SERIAL_SUB_OVF_EN
interface serial_subtractor_if import serial_sub_pkg::*; #(parameter int WIDTH = DEF_WIDTH);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             valid;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
  modport master (output start, a, b, bin, input ready, diff, bout, valid, ovf);
  modport slave  (input start, a, b, bin, output ready, diff, bout, valid, ovf);
`else
  modport master (output start, a, b, bin, input ready, diff, bout, valid);
  modport slave  (input start, a, b, bin, output ready, diff, bout, valid);
`endif
endinterface

// File: rtl/serial_subtractor_fullsub_d.sv
// fullsub_d: combinational one-bit full subtractor d = a - b - bi
module fullsub_d (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);
  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~a & bi) | (b & bi);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first bit-serial a-b-bin over WIDTH cycles; SERIAL_SUB_OVF_EN adds signed overflow
module serial_subtractor import serial_sub_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic           clk,
  input logic           rst_n,
  serial_subtractor_if.slave bus
);
  localparam int CW = cnt_w(WIDTH);
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_res, r_diff, w_res;
  logic [CW-1:0]    r_cnt;
  logic             r_bw, r_bout, r_valid, w_d, w_bo, w_last;
`ifdef SERIAL_SUB_OVF_EN
  logic             r_am, r_bm, r_ovf;
  assign bus.ovf = r_ovf;
`endif
  fullsub_d u_fs (.a(r_a[0]), .b(r_b[0]), .bi(r_bw), .d(w_d), .bo(w_bo));
  assign w_res  = {w_d, r_res[WIDTH-1:1]};
  assign w_last = r_cnt == CW'(WIDTH - 1);
  always_comb begin
    w_next = (r_state == IDLE) ? (bus.start ? SHIFT : IDLE) : (w_last ? IDLE : SHIFT);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_diff  <= '0;
      r_cnt   <= '0;
      r_bw    <= 1'b0;
      r_bout  <= 1'b0;
      r_valid <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      r_am    <= 1'b0;
      r_bm    <= 1'b0;
      r_ovf   <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      r_valid <= 1'b0;
      if (r_state == IDLE && bus.start) begin
        r_a   <= bus.a;
        r_b   <= bus.b;
        r_bw  <= bus.bin;
        r_cnt <= '0;
`ifdef SERIAL_SUB_OVF_EN
        r_am  <= bus.a[WIDTH-1];
        r_bm  <= bus.b[WIDTH-1];
`endif
      end else if (r_state == SHIFT) begin
        r_a   <= r_a >> 1;
        r_b   <= r_b >> 1;
        r_bw  <= w_bo;
        r_res <= w_res;
        r_cnt <= r_cnt + CW'(1);
        if (w_last) begin
          r_diff  <= w_res;
          r_bout  <= w_bo;
          r_valid <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
          r_ovf   <= (r_am != r_bm) && (w_d != r_am);
`endif
        end
      end
    end
  end
  assign bus.ready = r_state == IDLE;
  assign bus.diff  = r_diff;
  assign bus.bout  = r_bout;
  assign bus.valid = r_valid;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed vectors with a queue scoreboard checked by a valid-driven monitor
module tb_serial_subtractor;
  typedef struct {logic [7:0] d; logic bo; logic ov; int c;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic prev_v = 1'b0;
  exp_t q[$];
  serial_subtractor_if #(.WIDTH(8)) bus ();
  serial_subtractor #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && bus.valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_valid: got valid=1 expected no pending result");
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("diff", 32'(bus.diff), 32'(e.d));
        chk("bout", 32'(bus.bout), 32'(e.bo));
        chk("latency_cycle", 32'(cyc), 32'(e.c));
        chk("valid_single_cycle", 32'(prev_v), 32'(0));
`ifdef SERIAL_SUB_OVF_EN
        chk("ovf", 32'(bus.ovf), 32'(e.ov));
`endif
      end
    end
    prev_v = rst_n && bus.valid;
  end
  task automatic op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                    input logic [7:0] d, input logic bo, input logic ov, input logic b2b);
    int n = 0;
    @(negedge clk);
    while (!bus.ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got ready=0 expected ready=1 within 100 cycles");
    end
    if (b2b) chk("b2b_valid_with_ready", 32'(bus.valid), 32'(1));
    bus.start = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.bin = bin;
    q.push_back('{d: d, bo: bo, ov: ov, c: cyc + 9});
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a = 8'hxx;
    bus.b = 8'hxx;
    bus.bin = 1'bx;
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drained", 32'(q.size()), 32'(0));
    @(negedge clk);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.bin = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bus.ready), 32'(1));
    chk("rst_valid", 32'(bus.valid), 32'(0));
    chk("rst_diff", 32'(bus.diff), 32'(0));
    chk("rst_bout", 32'(bus.bout), 32'(0));
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ovf", 32'(bus.ovf), 32'(0));
`endif
    rst_n = 1'b1;
    op(8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0, 1'b0);
    drain();
    op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
    drain();
    op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0);
    drain();
    op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0);
    drain();
    op(8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
    op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1);
    drain();
    op(8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.a = 8'hFF;
    bus.b = 8'h00;
    bus.bin = 1'b0;
    @(negedge clk);
    chk("busy_ready_low", 32'(bus.ready), 32'(0));
    bus.start = 1'b0;
    @(negedge clk);
    chk("busy_ready_still_low", 32'(bus.ready), 32'(0));
    drain();
    op(8'hC3, 8'h11, 1'b0, 8'hB2, 1'b0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("midrst_ready", 32'(bus.ready), 32'(1));
    chk("midrst_valid", 32'(bus.valid), 32'(0));
    chk("midrst_diff", 32'(bus.diff), 32'(0));
    chk("midrst_bout", 32'(bus.bout), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("no_valid_after_reset", 32'(q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
